mips_ram_responder: RTL
=======================

MIPS_RAM_RESPONDER -- requirements
Module: mips_ram_responder

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the number of wait states between request capture and completion (legal range 0-15).
REQ-002 The block SHALL have parameter DEPTH, default 512, meaning the byte count of storage (byte-addressed, big-endian).
REQ-003 The block SHALL have one clock and a synchronous active-high reset: clk, reset.
REQ-004 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: mov  input  1  memory operation valid; the CPU holds it high until moc is seen.
REQ-007 Port: rw  input  1  1 = read, 0 = write.
REQ-008 Port: data_type  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
REQ-009 Port: address  input  9  byte address.
REQ-010 Port: data_in  input  32  write data, right-justified.
REQ-011 Port: data_out  output  32  read data, right-justified and zero-extended.
REQ-012 Port: moc  output  1  memory operation complete.
REQ-013 Port: err  output  1  request rejected; valid while moc = 1.

Function
REQ-014 The block SHALL hold storage as byte array Mem[0:DEPTH-1], preloadable by the bench, and SHALL NOT clear it on reset.
REQ-015 The block SHALL implement FSM states IDLE, BUSY and DONE.
REQ-016 IDLE with mov = 1 at an edge: latch rw, data_type, address and data_in; load counter = WAIT_CYCLES; go to BUSY. If WAIT_CYCLES = 0, perform the access on that edge and go directly to DONE.
REQ-017 BUSY: decrement the counter on every edge. On the edge where the counter equals 1, perform the access, set moc = 1, and go to DONE. moc therefore rises exactly WAIT_CYCLES edges after the capture edge.
REQ-018 Inputs SHALL be sampled only at the capture edge; changes to them during BUSY or DONE SHALL have no effect.
REQ-019 DONE: hold moc, data_out and err stable. On the first edge sampling mov = 0, clear moc and err and go to IDLE. data_out SHALL retain its last value.
REQ-020 mov falling during BUSY SHALL NOT abort the request: the access completes, and moc is then a single-cycle pulse.
REQ-021 A new request SHALL be accepted no earlier than the edge after the block returns to IDLE. A back-to-back request therefore has a minimum one-cycle idle gap.
REQ-022 Read access at latched address a:
- byte: data_out = {24'b0, Mem[a]}
- halfword: data_out = {16'b0, Mem[a], Mem[a+1]}
- word: data_out = {Mem[a], Mem[a+1], Mem[a+2], Mem[a+3]}
REQ-023 Write access at latched address a:
- byte: Mem[a] = data_in[7:0]
- halfword: Mem[a] = data_in[15:8], Mem[a+1] = data_in[7:0]
- word: Mem[a..a+3] = data_in[31:24], [23:16], [15:8], [7:0]
- data_out SHALL be unchanged.
REQ-024 Any of the following SHALL complete with err = 1 and moc = 1, perform no memory write, and leave data_out unchanged:
- halfword with a[0] != 0
- word with a[1:0] != 0
- data_type = 11
- last byte touched >= DEPTH
REQ-025 Exactly one access SHALL occur per accepted request; a read SHALL never modify Mem.

Reset
REQ-026 Reset SHALL force state = IDLE, moc = 0, err = 0, data_out = 0 and counter = 0, overriding all other inputs on that edge.
REQ-027 Reset asserted during BUSY SHALL discard the pending write, leave Mem unchanged, and keep moc low.
REQ-028 After reset deasserts with mov already high, the request SHALL be captured on the first non-reset edge.

Verification
REQ-029 Preload Mem[0..3] = 8C,01,00,2C; word read at address 0 -> moc rises 2 edges after capture, data_out = 32'h8C01002C, err = 0.
REQ-030 Word write of 32'hDEADBEEF at address 8, then byte read at 9 -> data_out = 32'h000000AD; halfword read at 10 -> data_out = 32'h0000BEEF.
REQ-031 Halfword write at address 5 with data_in = 32'h1234 -> err = 1 with moc, Mem[4..7] unchanged; mov low -> moc = 0 and err = 0 next edge.
REQ-032 Word write of 32'h11223344 at 12, reset pulsed during BUSY -> moc stays 0, Mem[12..15] keep their preload values.
REQ-033 mov held high through DONE for 5 cycles -> moc and data_out stable for all 5 cycles, no second access; drop mov, reassert next cycle -> a new capture occurs.
REQ-034 WAIT_CYCLES = 0 build: byte read at 3 -> moc = 1 on the capture edge, data_out = 32'h0000002C.

Source files
------------

// File: rtl/mips_ram_responder.sv
// mips_ram_responder: byte-addressed big-endian RAM answering a MIPS-style
// mov/moc handshake. It captures a request, waits WAIT_CYCLES edges, does a
// single access, then holds moc until the CPU drops mov.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   mov, rw, data_type  - request valid, 1=read/0=write, 00 byte/01 half/10 word
//   address, data_in    - byte address, right-justified write data
//   data_out, moc, err  - read data (zero-extended), op complete, request rejected
module mips_ram_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mov,
  input  logic        rw,
  input  logic [1:0]  data_type,
  input  logic [8:0]  address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        moc,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        lat_rw;
  logic [1:0]  lat_type;
  logic [8:0]  lat_addr;
  logic [31:0] lat_din;
  logic        err_q;
  logic [31:0] dout_q;
  logic [7:0]  mem [0:DEPTH-1];

  logic        capture, do_access;
  logic        acc_rw, acc_err;
  logic [1:0]  acc_type;
  logic [8:0]  acc_addr;
  logic [31:0] acc_din;
  logic [31:0] base, last, rd_word;
  logic [AW-1:0] idx0, idx1, idx2, idx3;

  assign capture   = (state == IDLE) && mov;
  // With zero wait states the access happens on the capture edge itself.
  assign do_access = (capture && (WAIT_CYCLES == 0)) || ((state == BUSY) && (cnt == 4'd1));

  // In IDLE the access (zero-wait case) sees the live inputs; otherwise only
  // the values latched at capture, so later input changes are ignored.
  assign acc_rw   = (state == IDLE) ? rw        : lat_rw;
  assign acc_type = (state == IDLE) ? data_type : lat_type;
  assign acc_addr = (state == IDLE) ? address   : lat_addr;
  assign acc_din  = (state == IDLE) ? data_in   : lat_din;

  always_comb begin
    base = {23'b0, acc_addr};
    case (acc_type)
      2'b00:   last = base;
      2'b01:   last = base + 32'd1;
      default: last = base + 32'd3;
    endcase
    acc_err = (acc_type == 2'b11)
           || ((acc_type == 2'b01) && acc_addr[0])
           || ((acc_type == 2'b10) && (acc_addr[1:0] != 2'b00))
           || (last >= 32'(DEPTH));
    idx0 = AW'(base);
    idx1 = AW'(base + 32'd1);
    idx2 = AW'(base + 32'd2);
    idx3 = AW'(base + 32'd3);
    case (acc_type)
      2'b00:   rd_word = {24'b0, mem[idx0]};
      2'b01:   rd_word = {16'b0, mem[idx0], mem[idx1]};
      default: rd_word = {mem[idx0], mem[idx1], mem[idx2], mem[idx3]};
    endcase
  end

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      err_q  <= 1'b0;
      dout_q <= 32'd0;
    end else begin
      state <= state_nxt;
      if (capture)
        cnt <= 4'(WAIT_CYCLES);
      else if (state == BUSY)
        cnt <= cnt - 4'd1;
      if (do_access) begin
        err_q <= acc_err;
        if (acc_rw && !acc_err)
          dout_q <= rd_word;
      end else if ((state == DONE) && !mov) begin
        err_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      lat_rw   <= rw;
      lat_type <= data_type;
      lat_addr <= address;
      lat_din  <= data_in;
    end
  end

  // Storage is never cleared; a reset edge suppresses any pending write.
  always_ff @(posedge clk) begin
    if (!reset && do_access && !acc_rw && !acc_err) begin
      case (acc_type)
        2'b00: mem[idx0] <= acc_din[7:0];
        2'b01: begin
          mem[idx0] <= acc_din[15:8];
          mem[idx1] <= acc_din[7:0];
        end
        default: begin
          mem[idx0] <= acc_din[31:24];
          mem[idx1] <= acc_din[23:16];
          mem[idx2] <= acc_din[15:8];
          mem[idx3] <= acc_din[7:0];
        end
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (mov) state_nxt = (WAIT_CYCLES == 0) ? DONE : BUSY;
      BUSY: if (cnt <= 4'd1) state_nxt = DONE;
      DONE: if (!mov) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    moc      = (state == DONE);
    err      = (state == DONE) && err_q;
    data_out = dout_q;
  end

endmodule
